mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum cycles MFA may stay high without MFC.
REQ-002 SHALL have port Clk, input, 1, the single system clock, rising-edge active.
REQ-003 SHALL have port Reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have the fetch requester ports: IF_REQ in 1; IF_ADDR in 32; IF_ACK out 1; IF_RDATA out 32.
REQ-005 SHALL have the load/store requester ports: LS_REQ in 1; LS_WR in 1 (1=store); LS_SIZE in 2 (0 byte, 1 half, 2 word, 3 dword); LS_ADDR in 32; LS_WDATA in 32; LS_ACK out 1; LS_RDATA out 32.
REQ-006 SHALL have the memory-side ports: MFA out 1; MFC in 1; MEM_ADDR out 32; MEM_WDATA out 32; MEM_RW out 1 (1=write); MEM_SIZE out 2; MEM_RDATA in 32.
REQ-007 SHALL have the fault ports: ALIGN_ERR out 1 and MEM_TIMEOUT out 1, each a one-cycle pulse coincident with the ACK it qualifies.

Function
REQ-008 SHALL implement the states IDLE, ACCESS, RELEASE and FAULT.
REQ-009 IDLE: when any REQ is high, SHALL register the grant, address, size, write flag and write data, then go to ACCESS the next cycle.
REQ-010 Arbitration: if only one requester asks, SHALL grant it; if both ask, SHALL grant the one not granted last (round-robin); after reset, LS SHALL win the first tie.
REQ-011 Alignment: if IF_ADDR[1:0]!=0, or the LS address is misaligned for LS_SIZE (half: bit0; word: bits1:0; dword: bits2:0), SHALL go to FAULT instead of ACCESS, and MFA SHALL never rise.
REQ-012 IF grants SHALL drive MEM_RW=0 and MEM_SIZE=2.
REQ-013 ACCESS: SHALL hold MFA=1 with MEM_* stable until MFC is sampled high; on that edge it SHALL capture MEM_RDATA into the granted RDATA register, pulse the granted ACK for one cycle, drop MFA, and go to RELEASE.
REQ-014 RELEASE: SHALL hold MFA=0 until MFC is sampled low, then return to IDLE, so no new access starts while MFC is high.
REQ-015 FAULT: SHALL pulse the granted ACK together with ALIGN_ERR for one cycle, leave RDATA unchanged, and return to IDLE.
REQ-016 A requester SHALL hold REQ and its operands until ACK; a REQ dropped before grant is ignored, and a REQ dropped after grant does not abort the access.
REQ-017 Minimum latency: REQ sampled at edge N, MFA high from N+1, ACK the cycle after the edge that samples MFC=1.
REQ-018 The non-granted ACK SHALL stay 0; at most one ACK SHALL be high in any cycle.
REQ-019 MEM_WDATA SHALL be don't-care unless MEM_RW=1; the LS_RDATA of a store SHALL remain unchanged.

Reset
REQ-020 When Reset=0, SHALL go to IDLE immediately; MFA, both ACKs, ALIGN_ERR and MEM_TIMEOUT SHALL be 0; MEM_ADDR, MEM_WDATA, both RDATAs and the timeout counter SHALL be 0; MEM_RW=0; MEM_SIZE=2; the round-robin pointer SHALL favour LS.
REQ-021 Reset during ACCESS SHALL drop MFA asynchronously and produce no ACK; after release, a still-high MFC SHALL block the first access as in RELEASE.

Configuration
REQ-022 With MEM_ARB_TIMEOUT_EN defined: a counter SHALL run in ACCESS; if MFC stays low for TIMEOUT_CYCLES cycles, the block SHALL drop MFA, pulse the ACK with MEM_TIMEOUT, and go to RELEASE.
REQ-023 Without MEM_ARB_TIMEOUT_EN: no counter SHALL exist, ACCESS SHALL wait indefinitely, and MEM_TIMEOUT SHALL be tied to 0.

Structure
REQ-024 A shared package SHALL hold the state encoding, the LS_SIZE encodings and the default TIMEOUT_CYCLES.
REQ-025 The alignment check SHALL be one combinational sub-module, mem_align_chk (inputs addr[2:0] and size; output misaligned).

Verification
REQ-026 IF_REQ with IF_ADDR=0x40 and MFC returned 3 cycles after MFA with MEM_RDATA=0x9C044012 -> single IF_ACK pulse, IF_RDATA=0x9C044012, MEM_RW=0.
REQ-027 IF_REQ and LS_REQ raised together twice in a row after reset -> LS is granted first, then IF; MFA never overlaps the preceding RELEASE.
REQ-028 LS store, size word, LS_ADDR=0x102 -> LS_ACK with ALIGN_ERR the cycle after grant; MFA stays 0.
REQ-029 MFC held high for 5 cycles after ACK while LS_REQ is pending -> MFA stays low until 1 cycle after MFC falls.
REQ-030 With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, MFC never asserted -> MFA drops after 16 cycles and IF_ACK pulses with MEM_TIMEOUT.
REQ-031 Reset driven low mid-ACCESS -> MFA falls with no clock edge, no ACK occurs, and all outputs match their REQ-020 values.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - state, access-size and timeout encodings shared by mem_arbiter
package mem_arbiter_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACCESS  = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;
    localparam logic [1:0] ST_FAULT   = 2'd3;

    localparam logic [1:0] SIZE_BYTE  = 2'd0;
    localparam logic [1:0] SIZE_HALF  = 2'd1;
    localparam logic [1:0] SIZE_WORD  = 2'd2;
    localparam logic [1:0] SIZE_DWORD = 2'd3;

    localparam int TIMEOUT_CYCLES_DEF = 16;

endpackage

// File: rtl/mem_align_chk.sv
// rtl/mem_align_chk.sv - flags an address that is not naturally aligned for its access size
module mem_align_chk
    import mem_arbiter_pkg::*;
(
    input  logic [2:0] addr,
    input  logic [1:0] size,
    output logic       misaligned
);

    always_comb begin
        misaligned = 1'b0;
        case (size)
            SIZE_BYTE:  misaligned = 1'b0;
            SIZE_HALF:  misaligned = addr[0];
            SIZE_WORD:  misaligned = |addr[1:0];
            SIZE_DWORD: misaligned = |addr[2:0];
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin fetch/load-store arbiter onto an MFA/MFC memory handshake
// Define MEM_ARB_TIMEOUT_EN to abort accesses whose MFC never arrives.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        IF_REQ,
    input  logic [31:0] IF_ADDR,
    output logic        IF_ACK,
    output logic [31:0] IF_RDATA,
    input  logic        LS_REQ,
    input  logic        LS_WR,
    input  logic [1:0]  LS_SIZE,
    input  logic [31:0] LS_ADDR,
    input  logic [31:0] LS_WDATA,
    output logic        LS_ACK,
    output logic [31:0] LS_RDATA,
    output logic        MFA,
    input  logic        MFC,
    output logic [31:0] MEM_ADDR,
    output logic [31:0] MEM_WDATA,
    output logic        MEM_RW,
    output logic [1:0]  MEM_SIZE,
    input  logic [31:0] MEM_RDATA,
    output logic        ALIGN_ERR,
    output logic        MEM_TIMEOUT
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    logic [1:0]  state_q, state_d;
    logic        grant_ls_q, grant_ls_d;
    logic        rr_ls_q, rr_ls_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic        rw_q, rw_d;
    logic [1:0]  size_q, size_d;
    logic        if_ack_q, if_ack_d, ls_ack_q, ls_ack_d, align_err_q, align_err_d;
    logic [31:0] if_rdata_q, if_rdata_d, ls_rdata_q, ls_rdata_d;
    logic        pick_ls, misaligned, timeout_hit;

    // LS wins when alone or when the round-robin pointer favours it on a tie
    assign pick_ls = LS_REQ && (!IF_REQ || rr_ls_q);

    mem_align_chk u_align (
        .addr       (pick_ls ? LS_ADDR[2:0] : IF_ADDR[2:0]),
        .size       (pick_ls ? LS_SIZE : SIZE_WORD),
        .misaligned (misaligned)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] cnt_q;
    logic             timeout_q, timeout_d;

    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign MEM_TIMEOUT = timeout_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= (state_q == ST_ACCESS && state_d == ST_ACCESS) ? cnt_q + CNT_W'(1) : '0;
            timeout_q <= timeout_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign MEM_TIMEOUT = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        grant_ls_d  = grant_ls_q;
        rr_ls_d     = rr_ls_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rw_d        = rw_q;
        size_d      = size_q;
        if_rdata_d  = if_rdata_q;
        ls_rdata_d  = ls_rdata_q;
        if_ack_d    = 1'b0;
        ls_ack_d    = 1'b0;
        align_err_d = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        timeout_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                // A lingering MFC (e.g. across a reset) must fall before a new grant
                if ((IF_REQ || LS_REQ) && !MFC) begin
                    grant_ls_d = pick_ls;
                    rr_ls_d    = !pick_ls;
                    addr_d     = pick_ls ? LS_ADDR : IF_ADDR;
                    wdata_d    = pick_ls ? LS_WDATA : wdata_q;
                    rw_d       = pick_ls && LS_WR;
                    size_d     = pick_ls ? LS_SIZE : SIZE_WORD;
                    if (misaligned) begin
                        state_d     = ST_FAULT;
                        if_ack_d    = !pick_ls;
                        ls_ack_d    = pick_ls;
                        align_err_d = 1'b1;
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                if (MFC) begin
                    state_d  = ST_RELEASE;
                    if_ack_d = !grant_ls_q;
                    ls_ack_d = grant_ls_q;
                    if (!rw_q) begin
                        if (grant_ls_q) ls_rdata_d = MEM_RDATA;
                        else            if_rdata_d = MEM_RDATA;
                    end
                end else if (timeout_hit) begin
                    state_d  = ST_RELEASE;
                    if_ack_d = !grant_ls_q;
                    ls_ack_d = grant_ls_q;
`ifdef MEM_ARB_TIMEOUT_EN
                    timeout_d = 1'b1;
`endif
                end
            end
            ST_RELEASE: if (!MFC) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= ST_IDLE;
            grant_ls_q  <= 1'b0;
            rr_ls_q     <= 1'b1;
            addr_q      <= '0;
            wdata_q     <= '0;
            rw_q        <= 1'b0;
            size_q      <= SIZE_WORD;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
            if_ack_q    <= 1'b0;
            ls_ack_q    <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_ls_q  <= grant_ls_d;
            rr_ls_q     <= rr_ls_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rw_q        <= rw_d;
            size_q      <= size_d;
            if_rdata_q  <= if_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
            if_ack_q    <= if_ack_d;
            ls_ack_q    <= ls_ack_d;
            align_err_q <= align_err_d;
        end
    end

    assign MFA       = (state_q == ST_ACCESS);
    assign MEM_ADDR  = addr_q;
    assign MEM_WDATA = wdata_q;
    assign MEM_RW    = rw_q;
    assign MEM_SIZE  = size_q;
    assign IF_ACK    = if_ack_q;
    assign LS_ACK    = ls_ack_q;
    assign IF_RDATA  = if_rdata_q;
    assign LS_RDATA  = ls_rdata_q;
    assign ALIGN_ERR = align_err_q;

endmodule
